mem_wb_stage_buf: RTL and testbench

//  Parametrised MEM/WB pipeline stage with a stall-tolerant holding buffer.

---
 rtl/mem_wb_pkg.sv | 27 ++
 rtl/mem_wb_stage_buf_if.sv | 38 +++
 rtl/mem_wb_stage_buf_chk.sv | 20 ++
 rtl/mem_wb_stage_buf_pipe_fifo.sv | 78 +++++++
 rtl/mem_wb_stage_buf.sv | 125 ++++++++++++
 tb/tb_mem_wb_stage_buf.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB stage buffer: write-back control bit
// positions, default widths, the beat record and the register-file write gate.
package mem_wb_pkg;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int MW_DATA_W = 32;
  localparam int MW_ADDR_W = 5;

  // Beat record at the default widths; the top rebuilds the same layout
  // from its own parameters so non-default widths stay consistent.
  typedef struct packed {
    logic [1:0]           wb;
    logic [MW_DATA_W-1:0] mem_data;
    logic [MW_DATA_W-1:0] alu_data;
    logic [MW_ADDR_W-1:0] rd;
  } mem_wb_beat_t;

  // Register-file write enable for a beat being loaded into the output register.
  function automatic logic rf_write_en(input logic [1:0] wb,
                                       input logic       rd_is_zero,
                                       input logic       zero_suppress);
    return wb[WB_REGWRITE] & ~(zero_suppress & rd_is_zero);
  endfunction

endpackage

// File: rtl/mem_wb_stage_buf_if.sv
// MEM-side handshake and WB-side result bus of the MEM/WB stage buffer.
// slave = the stage itself, master = whoever drives MEM and observes WB.
interface mem_wb_stage_buf_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [1:0]        WB_i;
  logic [DATA_W-1:0] MEM_data_i;
  logic [DATA_W-1:0] ALU_data_i;
  logic [ADDR_W-1:0] RegWriteAddr_i;
  logic              CacheStall_i;
  logic              flush_i;
  logic              valid_o;
  logic              RegWrite_o;
  logic              MemToReg_o;
  logic [DATA_W-1:0] Mem_data_o;
  logic [DATA_W-1:0] ALU_data_o;
  logic [ADDR_W-1:0] RegWriteAddr_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [CNT_W-1:0]  count_o;

  modport slave (
    input  in_valid_i, WB_i, MEM_data_i, ALU_data_i, RegWriteAddr_i,
           CacheStall_i, flush_i,
    output in_ready_o, valid_o, RegWrite_o, MemToReg_o, Mem_data_o,
           ALU_data_o, RegWriteAddr_o, wb_data_o, count_o
  );

  modport master (
    output in_valid_i, WB_i, MEM_data_i, ALU_data_i, RegWriteAddr_i,
           CacheStall_i, flush_i,
    input  in_ready_o, valid_o, RegWrite_o, MemToReg_o, Mem_data_o,
           ALU_data_o, RegWriteAddr_o, wb_data_o, count_o
  );
endinterface

// File: rtl/mem_wb_stage_buf_chk.sv
// Occupancy checker for the holding FIFO: overflow and underflow must be
// impossible given the handshake in the top.
module mem_wb_stage_buf_chk (
  input logic clk_i,
  input logic rst_i,
  input logic push_i,
  input logic pop_i,
  input logic full_i,
  input logic empty_i
);

  // A push into a full FIFO is only legal when a pop frees a slot that cycle.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full_i && !pop_i));

  // Nothing may ever be popped from an empty FIFO.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && empty_i));

endmodule

// File: rtl/mem_wb_stage_buf_pipe_fifo.sv
// Small register FIFO holding beats while WB is stalled. Pointers wrap
// modulo DEPTH (a power of two); clear_i empties it synchronously.
module pipe_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  T                 data_i,
  output T                 data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointer and occupancy values from push/pop/clear.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !clear_i) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;

endmodule

// File: rtl/mem_wb_stage_buf.sv
// MEM/WB pipeline stage: output register with bypass, a holding FIFO that
// absorbs beats while the cache stalls WB, flush and bubble insertion.
module mem_wb_stage_buf
  import mem_wb_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int DEPTH         = 2,
  parameter int ZERO_SUPPRESS = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  mem_wb_stage_buf_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [1:0]        wb;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu_data;
    logic [ADDR_W-1:0] rd;
  } beat_t;

  localparam logic ZS = (ZERO_SUPPRESS != 0);

  beat_t            in_beat_s;
  beat_t            head_s;
  beat_t            out_q, out_d;
  logic             valid_q, valid_d;
  logic             regwrite_q, regwrite_d;
  logic             ready_s;
  logic             accept_s;
  logic             push_s, pop_s, clear_s;
  logic             full_s, empty_s;
  logic [CNT_W-1:0] count_s;

  assign in_beat_s = '{wb: bus.WB_i, mem_data: bus.MEM_data_i,
                       alu_data: bus.ALU_data_i, rd: bus.RegWriteAddr_i};

  // Handshake: refuse only on flush, or when full and WB cannot drain.
  assign ready_s  = ~bus.flush_i & (~full_s | ~bus.CacheStall_i);
  assign accept_s = bus.in_valid_i & ready_s;

  // Output-register next state and FIFO control; flush beats stall beats load.
  always_comb begin
    out_d      = out_q;
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    clear_s    = 1'b0;
    if (bus.flush_i) begin
      clear_s    = 1'b1;
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
    end else if (bus.CacheStall_i) begin
      push_s = accept_s;
    end else if (!empty_s) begin
      // Oldest buffered beat goes first; a new beat queues behind it.
      pop_s      = 1'b1;
      push_s     = accept_s;
      out_d      = head_s;
      valid_d    = 1'b1;
      regwrite_d = rf_write_en(head_s.wb, (head_s.rd == {ADDR_W{1'b0}}), ZS);
    end else if (accept_s) begin
      out_d      = in_beat_s;
      valid_d    = 1'b1;
      regwrite_d = rf_write_en(in_beat_s.wb, (in_beat_s.rd == {ADDR_W{1'b0}}), ZS);
    end else begin
      // Bubble: data fields hold, only the qualifiers drop.
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
    end
  end

  // Output register toward WB and the register file.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q      <= '0;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
    end
  end

  pipe_fifo #(
    .T     (beat_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_s),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (in_beat_s),
    .data_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  mem_wb_stage_buf_chk u_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .full_i  (full_s),
    .empty_i (empty_s)
  );

  assign bus.in_ready_o     = ready_s;
  assign bus.valid_o        = valid_q;
  assign bus.RegWrite_o     = regwrite_q;
  assign bus.MemToReg_o     = out_q.wb[WB_MEMTOREG];
  assign bus.Mem_data_o     = out_q.mem_data;
  assign bus.ALU_data_o     = out_q.alu_data;
  assign bus.RegWriteAddr_o = out_q.rd;
  assign bus.wb_data_o      = out_q.wb[WB_MEMTOREG] ? out_q.mem_data : out_q.alu_data;
  assign bus.count_o        = count_s;

endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// Scoreboard bench for mem_wb_stage_buf: accepted beats are queued, the
// queue mirrors FIFO contents and the popped beat is what WB must show.
module tb_mem_wb_stage_buf;
  import mem_wb_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_wb_stage_buf_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(CNT_W)) bus ();

  mem_wb_stage_buf #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH), .ZERO_SUPPRESS(1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  mem_wb_beat_t q[$];
  mem_wb_beat_t cur;
  logic         cur_valid;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] rd);
    bus.in_valid_i     = v;
    bus.WB_i           = wb;
    bus.MEM_data_i     = mem;
    bus.ALU_data_i     = alu;
    bus.RegWriteAddr_i = rd;
  endtask

  task automatic compare_outputs();
    logic exp_rw;
    exp_rw = cur_valid & cur.wb[WB_REGWRITE] & (cur.rd != 5'd0);
    check_eq("valid_o",   64'(bus.valid_o),        64'(cur_valid));
    check_eq("RegWrite",  64'(bus.RegWrite_o),     64'(exp_rw));
    check_eq("MemToReg",  64'(bus.MemToReg_o),     64'(cur.wb[WB_MEMTOREG]));
    check_eq("mem_data",  64'(bus.Mem_data_o),     64'(cur.mem_data));
    check_eq("alu_data",  64'(bus.ALU_data_o),     64'(cur.alu_data));
    check_eq("rd",        64'(bus.RegWriteAddr_o), 64'(cur.rd));
    check_eq("wb_data",   64'(bus.wb_data_o),
             64'(cur.wb[WB_MEMTOREG] ? cur.mem_data : cur.alu_data));
    check_eq("count_o",   64'(bus.count_o),        64'(q.size()));
  endtask

  // One clock: sample handshake at negedge, update model, compare after posedge.
  task automatic step();
    logic acc, st, fl, rs;
    mem_wb_beat_t b;
    @(negedge clk);
    rs = rst;
    st = bus.CacheStall_i;
    fl = bus.flush_i;
    if (!rs) begin
      check_eq("in_ready", 64'(bus.in_ready_o),
               64'(!fl && !(q.size() == DEPTH && st)));
    end
    acc = bus.in_valid_i && bus.in_ready_o && !rs;
    b = '{wb: bus.WB_i, mem_data: bus.MEM_data_i, alu_data: bus.ALU_data_i,
          rd: bus.RegWriteAddr_i};
    if (rs) begin
      q.delete();
      cur_valid = 1'b0;
      cur = '0;
    end else if (fl) begin
      q.delete();
      cur_valid = 1'b0;
    end else begin
      if (acc) q.push_back(b);
      if (!st) begin
        if (q.size() > 0) begin
          cur = q.pop_front();
          cur_valid = 1'b1;
        end else begin
          cur_valid = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    cur = '0;
    cur_valid = 1'b0;
    bus.CacheStall_i = 1'b0;
    bus.flush_i = 1'b0;
    idle();

    // Reset state and release.
    #1;
    check_eq("rst_valid", 64'(bus.valid_o), 64'(1'b0));
    check_eq("rst_count", 64'(bus.count_o), 64'(0));
    check_eq("rst_ready", 64'(bus.in_ready_o), 64'(1'b1));
    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("rdy_after_rst", 64'(bus.in_ready_o), 64'(1'b1));

    // Streaming, one beat per cycle, ALU write-back.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b10, 32'h0, 32'h10 + 32'(i), 5'(i + 1));
      step();
    end
    idle();
    step();

    // Load path, then the same beat aimed at r0.
    drive(1'b1, 2'b11, 32'hDEADBEEF, 32'h4, 5'd3);
    step();
    check_eq("load_wbdata", 64'(bus.wb_data_o), 64'h0000_0000_DEAD_BEEF);
    drive(1'b1, 2'b11, 32'hDEADBEEF, 32'h4, 5'd0);
    step();
    check_eq("r0_regwrite", 64'(bus.RegWrite_o), 64'(1'b0));
    idle();
    step();

    // Stall fill: two accepted, two refused, then drain in order.
    bus.CacheStall_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'b10, 32'h0, 32'h100 + 32'(i), 5'(i));
      step();
    end
    bus.CacheStall_i = 1'b0;
    drive(1'b1, 2'b10, 32'h0, 32'h103, 5'd3);
    step();
    drive(1'b1, 2'b10, 32'h0, 32'h104, 5'd4);
    step();
    idle();
    repeat (3) step();

    // Flush during stall with a live output and two buffered beats.
    drive(1'b1, 2'b10, 32'h0, 32'hA0, 5'd10);
    step();
    bus.CacheStall_i = 1'b1;
    drive(1'b1, 2'b10, 32'h0, 32'hB0, 5'd11);
    step();
    drive(1'b1, 2'b10, 32'h0, 32'hC0, 5'd12);
    step();
    check_eq("pre_flush_count", 64'(bus.count_o), 64'(2));
    bus.flush_i = 1'b1;
    drive(1'b1, 2'b10, 32'h0, 32'hD0, 5'd13);
    step();
    check_eq("flush_valid", 64'(bus.valid_o), 64'(1'b0));
    check_eq("flush_count", 64'(bus.count_o), 64'(0));
    bus.flush_i = 1'b0;
    bus.CacheStall_i = 1'b0;
    idle();
    repeat (2) step();

    // Full, then unstall with continuous input: push and pop together.
    bus.CacheStall_i = 1'b1;
    drive(1'b1, 2'b10, 32'h0, 32'hE0, 5'd14);
    step();
    drive(1'b1, 2'b10, 32'h0, 32'hF0, 5'd15);
    step();
    bus.CacheStall_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b10, 32'h0, 32'h200 + 32'(i), 5'(16 + i));
      step();
      check_eq("full_unstall_cnt", 64'(bus.count_o), 64'(2));
    end
    idle();
    repeat (3) step();

    // Reset mid-stream with two beats buffered.
    bus.CacheStall_i = 1'b1;
    drive(1'b1, 2'b10, 32'h0, 32'h300, 5'd20);
    step();
    drive(1'b1, 2'b10, 32'h0, 32'h301, 5'd21);
    step();
    drive(1'b1, 2'b10, 32'h0, 32'h302, 5'd22);
    step();
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", 64'(bus.valid_o), 64'(1'b0));
    check_eq("midrst_rw",    64'(bus.RegWrite_o), 64'(1'b0));
    check_eq("midrst_count", 64'(bus.count_o), 64'(0));
    q.delete();
    cur_valid = 1'b0;
    cur = '0;
    bus.CacheStall_i = 1'b0;
    idle();
    step();
    rst = 1'b0;
    #1;
    check_eq("midrst_ready", 64'(bus.in_ready_o), 64'(1'b1));

    // Random traffic with occasional stall and flush.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom), $urandom, $urandom, 5'($urandom));
      bus.CacheStall_i = ($urandom_range(0, 2) == 0);
      bus.flush_i      = ($urandom_range(0, 19) == 0);
      step();
    end
    bus.flush_i = 1'b0;
    bus.CacheStall_i = 1'b0;
    idle();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
